// File: rtl/iter_shifter_pkg.sv
// Shared encodings for the iterative shifter: operation select codes and FSM states.
// Rotate support is controlled by the ALU_ROTATE_EN macro in the files that use these codes.
package iter_shifter_pkg;

   localparam logic [1:0] ALU_SH_SLL = 2'b00;
   localparam logic [1:0] ALU_SH_SRL = 2'b01;
   localparam logic [1:0] ALU_SH_SRA = 2'b10;
   localparam logic [1:0] ALU_SH_ROR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// Combinational single-bit shift step used once per SHIFT cycle.
// Macro ALU_ROTATE_EN: when defined, MODE 11 rotates right by one; otherwise MODE 11 passes D through.
module shift_step
   import iter_shifter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] D,
   input  logic [1:0]       MODE,
   output logic [WIDTH-1:0] Q
);

   always_comb begin
      Q = D;
      case (MODE)
         ALU_SH_SLL: Q = {D[WIDTH-2:0], 1'b0};
         ALU_SH_SRL: Q = {1'b0, D[WIDTH-1:1]};
         ALU_SH_SRA: Q = {D[WIDTH-1], D[WIDTH-1:1]};
`ifdef ALU_ROTATE_EN
         ALU_SH_ROR: Q = {D[0], D[WIDTH-1:1]};
`else
         ALU_SH_ROR: Q = D;
`endif
         default:    Q = D;
      endcase
   end

endmodule

// File: rtl/iter_shifter.sv
// Iterative shifter: one bit per cycle with valid/ready request and result handshakes.
// Macro ALU_ROTATE_EN: enables rotate-right on MODE 11; without it MODE 11 is a one-edge passthrough.
module iter_shifter
   import iter_shifter_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [SW-1:0]    SHAMT,
   input  logic [1:0]       MODE,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Y,
   output logic             busy,
   output logic [1:0]       dbg_state_o
);

   // Handshakes: a request is taken on a rising edge with in_valid && in_ready, and a result
   // is released on a rising edge with out_valid && out_ready; valid never waits on ready.

   state_e           state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [SW-1:0]    cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [WIDTH-1:0] step_q;
   logic             zero_lat;

   shift_step #(.WIDTH(WIDTH)) u_step (
      .D    (data_q),
      .MODE (mode_q),
      .Q    (step_q)
   );

`ifdef ALU_ROTATE_EN
   assign zero_lat = (SHAMT == '0);
`else
   assign zero_lat = (SHAMT == '0) || (MODE == ALU_SH_ROR);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= ALU_SH_SLL;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               data_d  = A;
               mode_d  = MODE;
               cnt_d   = SHAMT;
               state_d = zero_lat ? ST_DONE : ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            data_d = step_q;
            cnt_d  = cnt_q - SW'(1);
            if (cnt_q == SW'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready    = (state_q == ST_IDLE);
      out_valid   = (state_q == ST_DONE);
      busy        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
      dbg_state_o = state_q;
   end

   assign Y = data_q;

endmodule
